// File: rtl/alarm_bank.sv
// ---------------------------------------------------------------------------
// alarm_bank
//
// Multi-channel alarm unit. Each of the NUM_ALARMS channels stores an alarm
// time and compares it against the current 24-hour time on every seconds
// strobe. A matching channel drives its buzzer bit until the user stops or
// snoozes it, or until the optional ring timeout expires.
//
// Optional feature macro: ALARM_BANK_AUTO_STOP_EN
//   defined   -> a ringing channel returns to ARMED after RING_SEC ticks
//   undefined -> a ringing channel rings until stop, snooze or a config write
//
// Ports:
//   clk          system clock, all state updates on its rising edge
//   reset        asynchronous, active-low reset
//   sec_tick     one-cycle strobe marking a new second (cur_* valid)
//   cur_hour/min/sec   current time, binary
//   cfg_we       write configuration of channel cfg_idx
//   cfg_idx      channel being configured
//   cfg_hour/min/sec   alarm time to store
//   cfg_enable   1 = arm the channel, 0 = disable it
//   snooze, stop level-sampled user controls for channel op_idx
//   op_idx       target channel for snooze/stop
//   buzzer       bit i high while channel i rings
//   alarm_any    OR of buzzer
//   ringing_idx  lowest-numbered ringing channel, 0 when none rings
//   cfg_err      one-cycle pulse after a rejected config write
// ---------------------------------------------------------------------------
module alarm_bank #(
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60,
  parameter int IDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sec_tick,
  input  logic [7:0]            cur_hour,
  input  logic [7:0]            cur_min,
  input  logic [7:0]            cur_sec,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [7:0]            cfg_hour,
  input  logic [7:0]            cfg_min,
  input  logic [7:0]            cfg_sec,
  input  logic                  cfg_enable,
  input  logic                  snooze,
  input  logic                  stop,
  input  logic [IDX_W-1:0]      op_idx,
  output logic [NUM_ALARMS-1:0] buzzer,
  output logic                  alarm_any,
  output logic [IDX_W-1:0]      ringing_idx,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RINGING,
    ST_SNOOZED
  } state_e;

  localparam logic [15:0] SnoozeLoad = 16'(SNOOZE_SEC);
  localparam logic [15:0] RingLoad   = 16'(RING_SEC);

  state_e      state_q [NUM_ALARMS];
  state_e      state_d [NUM_ALARMS];
  logic [7:0]  hour_q  [NUM_ALARMS];
  logic [7:0]  hour_d  [NUM_ALARMS];
  logic [7:0]  min_q   [NUM_ALARMS];
  logic [7:0]  min_d   [NUM_ALARMS];
  logic [7:0]  sec_q   [NUM_ALARMS];
  logic [7:0]  sec_d   [NUM_ALARMS];
  logic [15:0] cnt_q   [NUM_ALARMS];
  logic [15:0] cnt_d   [NUM_ALARMS];

  logic [NUM_ALARMS-1:0] buzzer_q, buzzer_d;
  logic                  any_q, any_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  cfg_err_q, cfg_err_d;

  logic                  cfg_valid;
  logic [NUM_ALARMS-1:0] cfg_hit;
  logic [NUM_ALARMS-1:0] op_hit;
  logic [NUM_ALARMS-1:0] time_match;

  // Decode which channel a config write or user control is aimed at, and
  // which channels see their stored time on this seconds strobe. The match
  // uses the stored (old) time, so a write never matches in its own cycle.
  assign cfg_valid = (cfg_hour <= 8'd23) && (cfg_min <= 8'd59) && (cfg_sec <= 8'd59);

  always_comb begin
    cfg_hit    = '0;
    op_hit     = '0;
    time_match = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      cfg_hit[i]    = cfg_we && cfg_valid && (cfg_idx == IDX_W'(i));
      op_hit[i]     = (op_idx == IDX_W'(i));
      time_match[i] = sec_tick && (cur_hour == hour_q[i]) &&
                      (cur_min == min_q[i]) && (cur_sec == sec_q[i]);
    end
  end

  // Per-channel next-state logic. An accepted config write overrides
  // everything; otherwise stop beats snooze, and both beat any counter
  // expiry in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      state_d[i] = state_q[i];
      hour_d[i]  = hour_q[i];
      min_d[i]   = min_q[i];
      sec_d[i]   = sec_q[i];
      cnt_d[i]   = cnt_q[i];

      if (cfg_hit[i]) begin
        hour_d[i]  = cfg_hour;
        min_d[i]   = cfg_min;
        sec_d[i]   = cfg_sec;
        cnt_d[i]   = '0;
        state_d[i] = cfg_enable ? ST_ARMED : ST_IDLE;
      end else begin
        unique case (state_q[i])
          ST_IDLE: begin
          end
          ST_ARMED: begin
            if (time_match[i]) begin
              state_d[i] = ST_RINGING;
              cnt_d[i]   = RingLoad;
            end
          end
          ST_RINGING: begin
            if (stop && op_hit[i]) begin
              state_d[i] = ST_ARMED;
            end else if (snooze && op_hit[i]) begin
              state_d[i] = ST_SNOOZED;
              cnt_d[i]   = SnoozeLoad;
            end
`ifdef ALARM_BANK_AUTO_STOP_EN
            else if (sec_tick) begin
              // Counter reaching zero on this tick ends the ring.
              if (cnt_q[i] <= 16'd1) begin
                cnt_d[i]   = '0;
                state_d[i] = ST_ARMED;
              end else begin
                cnt_d[i] = cnt_q[i] - 16'd1;
              end
            end
`endif
          end
          ST_SNOOZED: begin
            if (stop && op_hit[i]) begin
              state_d[i] = ST_ARMED;
            end else if (sec_tick) begin
              // Counter reaching zero on this tick restarts the ring.
              if (cnt_q[i] <= 16'd1) begin
                state_d[i] = ST_RINGING;
                cnt_d[i]   = RingLoad;
              end else begin
                cnt_d[i] = cnt_q[i] - 16'd1;
              end
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
          end
        endcase
      end
    end
  end

  // Output next-values are derived from the next state so that buzzer,
  // alarm_any and ringing_idx all change on the same edge as the state.
  always_comb begin
    buzzer_d = '0;
    idx_d    = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      buzzer_d[i] = (state_d[i] == ST_RINGING);
    end
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (buzzer_d[i]) begin
        idx_d = IDX_W'(i);
      end
    end
    any_d     = |buzzer_d;
    cfg_err_d = cfg_we && !cfg_valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        state_q[i] <= ST_IDLE;
        hour_q[i]  <= '0;
        min_q[i]   <= '0;
        sec_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
      buzzer_q  <= '0;
      any_q     <= 1'b0;
      idx_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        state_q[i] <= state_d[i];
        hour_q[i]  <= hour_d[i];
        min_q[i]   <= min_d[i];
        sec_q[i]   <= sec_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      buzzer_q  <= buzzer_d;
      any_q     <= any_d;
      idx_q     <= idx_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign buzzer      = buzzer_q;
  assign alarm_any   = any_q;
  assign ringing_idx = idx_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_alarm_bank.sv
// ---------------------------------------------------------------------------
// tb_alarm_bank
//
// Directed bench for alarm_bank with NUM_ALARMS=4, SNOOZE_SEC=5, RING_SEC=10.
// Stimulus pushes the expected outputs for each clock edge into a queue; a
// separate monitor pops and compares them on the following falling edge.
// ---------------------------------------------------------------------------
module tb_alarm_bank;

  logic       clk;
  logic       reset;
  logic       secTick;
  logic [7:0] curHour, curMin, curSec;
  logic       cfgWe;
  logic [1:0] cfgIdx;
  logic [7:0] cfgHour, cfgMin, cfgSec;
  logic       cfgEnable;
  logic       snooze, stop;
  logic [1:0] opIdx;
  logic [3:0] buzzer;
  logic       alarmAny;
  logic [1:0] ringingIdx;
  logic       cfgErr;

  typedef struct {
    string      name;
    logic [3:0] buz;
    logic [1:0] idx;
    logic       any;
    logic       err;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  alarm_bank #(
    .NUM_ALARMS(4),
    .SNOOZE_SEC(5),
    .RING_SEC  (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sec_tick   (secTick),
    .cur_hour   (curHour),
    .cur_min    (curMin),
    .cur_sec    (curSec),
    .cfg_we     (cfgWe),
    .cfg_idx    (cfgIdx),
    .cfg_hour   (cfgHour),
    .cfg_min    (cfgMin),
    .cfg_sec    (cfgSec),
    .cfg_enable (cfgEnable),
    .snooze     (snooze),
    .stop       (stop),
    .op_idx     (opIdx),
    .buzzer     (buzzer),
    .alarm_any  (alarmAny),
    .ringing_idx(ringingIdx),
    .cfg_err    (cfgErr)
  );

  // Free-running 100 MHz-style clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected ringing index: lowest set bit of the expected buzzer vector.
  function automatic logic [1:0] lowestIdx(input logic [3:0] b);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (b[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic int hms(input int h, input int m, input int s);
    return h * 3600 + m * 60 + s;
  endfunction

  // Compare one expected record against the DUT outputs.
  task automatic checkOutput(input exp_t e);
    checks++;
    if ({buzzer, ringingIdx, alarmAny, cfgErr} !== {e.buz, e.idx, e.any, e.err}) begin
      errors++;
      $display("[TB] FAIL %s: got buzzer=%b idx=%0d any=%b err=%b, expected buzzer=%b idx=%0d any=%b err=%b",
               e.name, buzzer, ringingIdx, alarmAny, cfgErr, e.buz, e.idx, e.any, e.err);
    end
  endtask

  // Monitor: every falling edge, check the record queued for the last edge.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // One clock edge with the inputs already driven; the expected post-edge
  // outputs are queued, then one-shot controls are dropped at the falling edge.
  task automatic applyStimulus(input string name, input logic [3:0] expBuz, input logic expErr);
    exp_t e;
    @(posedge clk);
    e.name = name;
    e.buz  = expBuz;
    e.idx  = lowestIdx(expBuz);
    e.any  = |expBuz;
    e.err  = expErr;
    expQ.push_back(e);
    @(negedge clk);
    secTick = 1'b0;
    cfgWe   = 1'b0;
    snooze  = 1'b0;
    stop    = 1'b0;
  endtask

  task automatic setTick(input int t);
    curHour = 8'(t / 3600);
    curMin  = 8'((t / 60) % 60);
    curSec  = 8'(t % 60);
    secTick = 1'b1;
  endtask

  task automatic tickAt(input int t, input string name, input logic [3:0] expBuz);
    setTick(t);
    applyStimulus(name, expBuz, 1'b0);
  endtask

  task automatic setCfg(input logic [1:0] idx, input int h, input int m, input int s, input logic en);
    cfgWe     = 1'b1;
    cfgIdx    = idx;
    cfgHour   = 8'(h);
    cfgMin    = 8'(m);
    cfgSec    = 8'(s);
    cfgEnable = en;
  endtask

  task automatic setOp(input logic [1:0] idx, input logic doSnooze, input logic doStop);
    opIdx  = idx;
    snooze = doSnooze;
    stop   = doStop;
  endtask

  // Directed scenarios, each with hand-computed expected outputs.
  initial begin
    reset = 1'b0;
    secTick = 1'b0; curHour = '0; curMin = '0; curSec = '0;
    cfgWe = 1'b0; cfgIdx = '0; cfgHour = '0; cfgMin = '0; cfgSec = '0; cfgEnable = 1'b0;
    snooze = 1'b0; stop = 1'b0; opIdx = '0;

    applyStimulus("resetInit0", 4'b0000, 1'b0);
    applyStimulus("resetInit1", 4'b0000, 1'b0);
    reset = 1'b1;
    applyStimulus("idleAfterReset", 4'b0000, 1'b0);

    // Reset in the middle of a ring.
    setCfg(2'd0, 0, 0, 30, 1'b1);
    applyStimulus("cfgCh0", 4'b0000, 1'b0);
    tickAt(hms(0, 0, 29), "ch0Before", 4'b0000);
    tickAt(hms(0, 0, 30), "ch0Match", 4'b0001);
    tickAt(hms(0, 0, 31), "ch0StillRing", 4'b0001);
    setTick(hms(0, 0, 32));
    reset = 1'b0;
    applyStimulus("resetDuring0", 4'b0000, 1'b0);
    applyStimulus("resetDuring1", 4'b0000, 1'b0);
    reset = 1'b1;
    applyStimulus("resetAfter", 4'b0000, 1'b0);
    tickAt(hms(0, 0, 30), "ch0IdleAfterReset", 4'b0000);

    // Snooze cycle on channel 1.
    setCfg(2'd1, 12, 0, 0, 1'b1);
    applyStimulus("cfgCh1", 4'b0000, 1'b0);
    tickAt(hms(11, 59, 59), "ch1Before", 4'b0000);
    tickAt(hms(12, 0, 0), "ch1Match", 4'b0010);
    tickAt(hms(12, 0, 1), "ch1Ring1", 4'b0010);
    tickAt(hms(12, 0, 2), "ch1Ring2", 4'b0010);
    setOp(2'd0, 1'b1, 1'b0);
    applyStimulus("snoozeWrongCh", 4'b0010, 1'b0);
    setOp(2'd1, 1'b1, 1'b0);
    applyStimulus("snoozeCh1", 4'b0000, 1'b0);
    for (int k = 3; k <= 6; k++) tickAt(hms(12, 0, k), "snoozed", 4'b0000);
    tickAt(hms(12, 0, 7), "snoozeExpire", 4'b0010);
    setOp(2'd1, 1'b0, 1'b1);
    applyStimulus("stopCh1", 4'b0000, 1'b0);
    tickAt(hms(12, 0, 8), "ch1Armed", 4'b0000);
    tickAt(hms(12, 0, 0), "ch1NextDay", 4'b0010);
    setOp(2'd1, 1'b0, 1'b1);
    applyStimulus("stopCh1b", 4'b0000, 1'b0);

    // Two channels ringing together.
    setCfg(2'd2, 23, 59, 59, 1'b1);
    applyStimulus("cfgCh2", 4'b0000, 1'b0);
    setCfg(2'd3, 23, 59, 59, 1'b1);
    applyStimulus("cfgCh3", 4'b0000, 1'b0);
    tickAt(hms(23, 59, 58), "simBefore", 4'b0000);
    tickAt(hms(23, 59, 59), "simMatch", 4'b1100);
    setOp(2'd2, 1'b0, 1'b1);
    applyStimulus("stopCh2", 4'b1000, 1'b0);
    setOp(2'd3, 1'b0, 1'b1);
    applyStimulus("stopCh3", 4'b0000, 1'b0);

    // Rejected config writes leave time and state untouched.
    setCfg(2'd0, 24, 0, 0, 1'b1);
    applyStimulus("badHour", 4'b0000, 1'b1);
    applyStimulus("badHourErrDrop", 4'b0000, 1'b0);
    tickAt(hms(24, 0, 0), "badHourNotStored", 4'b0000);
    tickAt(hms(0, 0, 30), "ch0StillIdle", 4'b0000);
    setCfg(2'd1, 12, 60, 0, 1'b0);
    applyStimulus("badMin", 4'b0000, 1'b1);
    tickAt(hms(12, 0, 0), "ch1StillArmed", 4'b0010);
    setOp(2'd1, 1'b0, 1'b1);
    applyStimulus("stopCh1c", 4'b0000, 1'b0);

    // A write never matches in the cycle it lands.
    setCfg(2'd0, 7, 0, 0, 1'b1);
    setTick(hms(7, 0, 0));
    applyStimulus("writeNoSameCycleMatch", 4'b0000, 1'b0);
    tickAt(hms(7, 0, 0), "ch0MatchLater", 4'b0001);
    setOp(2'd0, 1'b0, 1'b1);
    applyStimulus("stopCh0", 4'b0000, 1'b0);

    // Ring with no user action.
    setCfg(2'd0, 6, 0, 0, 1'b1);
    applyStimulus("cfgCh0Auto", 4'b0000, 1'b0);
    tickAt(hms(6, 0, 0), "autoMatch", 4'b0001);
`ifdef ALARM_BANK_AUTO_STOP_EN
    for (int k = 1; k <= 9; k++) tickAt(hms(6, 0, 0) + k, "autoRinging", 4'b0001);
    tickAt(hms(6, 0, 10), "autoTimeout", 4'b0000);
    tickAt(hms(6, 0, 11), "autoArmed", 4'b0000);
    tickAt(hms(6, 0, 0), "autoNextDay", 4'b0001);
`else
    for (int k = 1; k <= 101; k++) tickAt(hms(6, 0, 0) + k, "persistRinging", 4'b0001);
`endif
    setOp(2'd0, 1'b0, 1'b1);
    applyStimulus("stopCh0Auto", 4'b0000, 1'b0);

    // Stop beats snooze in the same cycle.
    tickAt(hms(12, 0, 0), "prioRing", 4'b0010);
    setOp(2'd1, 1'b1, 1'b1);
    applyStimulus("stopBeatsSnooze", 4'b0000, 1'b0);
    for (int k = 1; k <= 5; k++) tickAt(hms(12, 0, k), "noSnoozeRing", 4'b0000);

    // Config write beats stop: the new time must take effect.
    tickAt(hms(12, 0, 0), "prioRing2", 4'b0010);
    setCfg(2'd1, 13, 0, 0, 1'b1);
    setOp(2'd1, 1'b0, 1'b1);
    applyStimulus("cfgBeatsStop", 4'b0000, 1'b0);
    tickAt(hms(12, 0, 0), "oldTimeGone", 4'b0000);
    tickAt(hms(13, 0, 0), "newTimeRings", 4'b0010);

    // Config write beats snooze: no re-ring after the snooze length.
    setCfg(2'd1, 13, 0, 10, 1'b1);
    setOp(2'd1, 1'b1, 1'b0);
    applyStimulus("cfgBeatsSnooze", 4'b0000, 1'b0);
    for (int k = 1; k <= 5; k++) tickAt(hms(13, 0, k), "noSnoozeAfterCfg", 4'b0000);
    tickAt(hms(13, 0, 10), "cfgTimeRings", 4'b0010);
    setOp(2'd1, 1'b0, 1'b1);
    applyStimulus("finalStop", 4'b0000, 1'b0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queueDrain: got %0d pending, expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
